// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state type, frame geometry and a
// 2-of-3 majority helper used when UART_RECV_MAJORITY_EN is defined.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    localparam int UART_DATA_W    = 8;
    localparam int UART_STOP_BITS = 1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for asynchronous inputs; resets to 1 so an idle-high
// line never produces a spurious falling edge out of reset.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic meta_r;

    // Metastability filter: two back-to-back flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b1;
            dout   <= 1'b1;
        end else begin
            meta_r <= din;
            dout   <= meta_r;
        end
    end

endmodule

// File: rtl/uart_recv.sv
// 8N1 UART receiver with OVERSAMPLE clocks per bit. Define
// UART_RECV_MAJORITY_EN to take every sample as a 2-of-3 majority vote.
module uart_recv
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       sys_clk,
    input  logic       sys_reset_n,
    input  logic       uart_rx,
    output logic [7:0] o_recv_data,
    output logic       o_recv_data_en,
    output logic       o_frame_err,
    output logic       uart_busy
);

    localparam int                CNT_W    = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
    localparam logic [2:0]        LAST_BIT = 3'(UART_DATA_W - 1);

    logic                   rx_s;
    logic                   rx_d;
    logic                   sample_s;
    uart_rx_state_t         state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [2:0]             bit_idx_r;
    logic [UART_DATA_W-1:0] shift_r;

    uart_rx_sync u_sync (
        .clk  (sys_clk),
        .rst_n(sys_reset_n),
        .din  (uart_rx),
        .dout (rx_s)
    );

`ifdef UART_RECV_MAJORITY_EN
    logic [1:0] hist_r;

    // Two previous rx_s values; together with the live value they form the vote window.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            hist_r <= 2'b11;
        end else begin
            hist_r <= {hist_r[0], rx_s};
        end
    end

    assign sample_s = maj3(rx_s, hist_r[0], hist_r[1]);
`else
    assign sample_s = rx_s;
`endif

    // Frame FSM with edge detector, bit timing and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_r        <= IDLE;
            cnt_r          <= CNT_ZERO;
            bit_idx_r      <= 3'd0;
            shift_r        <= {UART_DATA_W{1'b0}};
            rx_d           <= 1'b1;
            o_recv_data    <= 8'h00;
            o_recv_data_en <= 1'b0;
            o_frame_err    <= 1'b0;
            uart_busy      <= 1'b0;
        end else begin
            rx_d           <= rx_s;
            o_recv_data_en <= 1'b0;
            o_frame_err    <= 1'b0;
            case (state_r)
                IDLE: begin
                    cnt_r <= CNT_ZERO;
                    if (rx_d && !rx_s) begin
                        state_r   <= START;
                        uart_busy <= 1'b1;
                    end else begin
                        uart_busy <= 1'b0;
                    end
                end
                START: begin
                    if (cnt_r == CNT_HALF) begin
                        cnt_r <= CNT_ZERO;
                        if (!sample_s) begin
                            state_r   <= DATA;
                            bit_idx_r <= 3'd0;
                        end else begin
                            // Line already back high at mid start bit: a glitch.
                            state_r   <= IDLE;
                            uart_busy <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r     <= CNT_ZERO;
                        shift_r   <= {sample_s, shift_r[UART_DATA_W-1:1]};
                        bit_idx_r <= bit_idx_r + 3'd1;
                        if (bit_idx_r == LAST_BIT) begin
                            state_r <= STOP;
                        end else begin
                            state_r <= DATA;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r     <= CNT_ZERO;
                        state_r   <= IDLE;
                        uart_busy <= 1'b0;
                        if (sample_s) begin
                            o_recv_data    <= shift_r;
                            o_recv_data_en <= 1'b1;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= CNT_ZERO;
                    uart_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_recv.sv
// Self-checking bench for uart_recv (OVERSAMPLE=16): directed corner cases,
// a table of frames and randomized frames checked against a frame-level model.
module tb_uart_recv;

    localparam int OS    = 16;
    localparam int FRAME = 10 * OS;
    // Cycles from driving the start bit to the output pulse:
    // 2 synchronizer cycles, half a bit to the start sample, 9 bits to the stop sample, 1 register.
    localparam int PULSE_OFS = 2 + OS / 2 + 9 * OS + 1;

    logic       sys_clk = 1'b0;
    logic       sys_reset_n = 1'b0;
    logic       uart_rx = 1'b1;
    logic [7:0] o_recv_data;
    logic       o_recv_data_en;
    logic       o_frame_err;
    logic       uart_busy;

    uart_recv #(.OVERSAMPLE(OS)) dut (
        .sys_clk       (sys_clk),
        .sys_reset_n   (sys_reset_n),
        .uart_rx       (uart_rx),
        .o_recv_data   (o_recv_data),
        .o_recv_data_en(o_recv_data_en),
        .o_frame_err   (o_frame_err),
        .uart_busy     (uart_busy)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       err;
        logic [7:0] data;
    } ev_t;

    ev_t  evq[$];
    int   busy_rise[$];
    int   busy_fall[$];
    logic busy_prev = 1'b0;
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output monitor: records every pulse and busy transition with its cycle.
    always @(negedge sys_clk) begin
        if (o_recv_data_en || o_frame_err) begin
            check("pulse_exclusive", {31'd0, o_recv_data_en & o_frame_err}, 32'd0);
            evq.push_back('{cyc, o_frame_err, o_recv_data});
        end
        if (uart_busy !== busy_prev) begin
            if (uart_busy) busy_rise.push_back(cyc);
            else           busy_fall.push_back(cyc);
        end
        busy_prev = uart_busy;
    end

    // Drive the first len cycles of an 8N1 frame; optionally invert one cycle.
    task automatic send_bits(input logic [7:0] d, input logic stop, input int glitch,
                             input int len, output int start);
        logic [9:0] frame;
        logic       v;
        frame = {stop, d, 1'b0};
        start = cyc;
        for (int i = 0; i < len; i++) begin
            v = frame[i / OS];
            if (i == glitch) v = ~v;
            uart_rx = v;
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic stop, output int start);
        send_bits(d, stop, -1, FRAME, start);
    endtask

    task automatic line(input logic lvl, input int n);
        uart_rx = lvl;
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic expect_event(input string name, input logic err, input logic [7:0] data,
                                input int at);
        ev_t ev;
        if (evq.size() == 0) begin
            check({name, "_present"}, 32'd0, 32'd1);
        end else begin
            ev = evq.pop_front();
            check({name, "_kind"}, {31'd0, ev.err}, {31'd0, err});
            check({name, "_data"}, {24'd0, ev.data}, {24'd0, data});
            check({name, "_cycle"}, ev.cyc, at);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         gap;
        logic       exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t       vecs[6];
    int         s, s2;
    ev_t        e1;
    logic [7:0] last_good;
    logic [7:0] rd;
    logic       rstop;
    int         rgap;
    logic [7:0] glitch_exp;

    initial begin
        vecs[0] = '{8'h01, 1'b1, 0,      1'b0, 8'h01};
        vecs[1] = '{8'h80, 1'b1, OS,     1'b0, 8'h80};
        vecs[2] = '{8'hC3, 1'b0, OS / 2, 1'b1, 8'h80};
        vecs[3] = '{8'h7E, 1'b1, 3,      1'b0, 8'h7E};
        vecs[4] = '{8'h5A, 1'b1, 0,      1'b0, 8'h5A};
        vecs[5] = '{8'hE7, 1'b0, 2 * OS, 1'b1, 8'h5A};

        // Reset values
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_data", {24'd0, o_recv_data}, 32'h00);
        check("rst_en", {31'd0, o_recv_data_en}, 32'd0);
        check("rst_err", {31'd0, o_frame_err}, 32'd0);
        check("rst_busy", {31'd0, uart_busy}, 32'd0);
        @(posedge sys_clk);
        #1;
        sys_reset_n = 1'b1;
        line(1'b1, 2 * OS);

        // 1: clean 0xA5
        busy_rise.delete();
        busy_fall.delete();
        send(8'hA5, 1'b1, s);
        line(1'b1, OS);
        expect_event("a5", 1'b0, 8'hA5, s + PULSE_OFS);
        check("a5_hold", {24'd0, o_recv_data}, 32'hA5);
        check("a5_busy_rises", busy_rise.size(), 1);
        check("a5_busy_falls", busy_fall.size(), 1);
        if (busy_rise.size() > 0) check("a5_busy_rise_cyc", busy_rise[0], s + 3);
        if (busy_fall.size() > 0) check("a5_busy_fall_cyc", busy_fall[0], s + PULSE_OFS);

        // 2: 3-cycle low glitch
        line(1'b0, 3);
        line(1'b1, 3 * OS);
        check("glitch_no_event", evq.size(), 0);
        check("glitch_hold", {24'd0, o_recv_data}, 32'hA5);
        check("glitch_busy", {31'd0, uart_busy}, 32'd0);

        // 3: good frame, framing error, then a long break
        send(8'h3C, 1'b1, s);
        expect_event("f3c", 1'b0, 8'h3C, s + PULSE_OFS);
        send(8'h81, 1'b0, s);
        expect_event("ferr", 1'b1, 8'h3C, s + PULSE_OFS);
        check("ferr_hold", {24'd0, o_recv_data}, 32'h3C);
        line(1'b0, 40 * OS);
        check("break_no_event", evq.size(), 0);
        check("break_busy", {31'd0, uart_busy}, 32'd0);
        line(1'b1, 2 * OS);
        check("break_release_no_event", evq.size(), 0);

        // 4: back-to-back 0x00, 0xFF
        send(8'h00, 1'b1, s);
        send(8'hFF, 1'b1, s2);
        line(1'b1, OS);
        e1 = evq.size() > 0 ? evq[0] : '{0, 1'b0, 8'h00};
        expect_event("b2b_00", 1'b0, 8'h00, s + PULSE_OFS);
        expect_event("b2b_ff", 1'b0, 8'hFF, s2 + PULSE_OFS);
        check("b2b_spacing", s2 + PULSE_OFS - e1.cyc, 160);

        // 5: reset during data bit 4 of 0x55
        send_bits(8'h55, 1'b1, -1, 5 * OS + OS / 2, s);
        check("pre_rst_busy", {31'd0, uart_busy}, 32'd1);
        sys_reset_n = 1'b0;
        #1;
        check("midrst_data", {24'd0, o_recv_data}, 32'h00);
        check("midrst_busy", {31'd0, uart_busy}, 32'd0);
        repeat (2) @(posedge sys_clk);
        #1;
        sys_reset_n = 1'b1;
        line(1'b1, 3 * OS);
        check("midrst_no_event", evq.size(), 0);
        send(8'h12, 1'b1, s);
        line(1'b1, OS);
        expect_event("after_rst", 1'b0, 8'h12, s + PULSE_OFS);

        // 6: one-cycle glitch at the bit-3 sample point
`ifdef UART_RECV_MAJORITY_EN
        glitch_exp = 8'h00;
`else
        glitch_exp = 8'h08;
`endif
        send_bits(8'h00, 1'b1, OS / 2 + 4 * OS, FRAME, s);
        line(1'b1, OS);
        expect_event("bit3_glitch", 1'b0, glitch_exp, s + PULSE_OFS);

        // Table of frames
        last_good = glitch_exp;
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].d, vecs[i].stop, s);
            if (vecs[i].gap > 0) line(1'b1, vecs[i].gap);
            expect_event($sformatf("vec%0d", i), vecs[i].exp_err, vecs[i].exp_data, s + PULSE_OFS);
            check($sformatf("vec%0d_hold", i), {24'd0, o_recv_data}, {24'd0, vecs[i].exp_data});
        end
        line(1'b1, OS);

        // Randomized frames against a frame-level model
        last_good = 8'h5A;
        for (int i = 0; i < 30; i++) begin
            rd    = 8'($urandom_range(0, 255));
            rstop = ($urandom_range(0, 5) != 0);
            rgap  = rstop ? $urandom_range(0, 2 * OS) : $urandom_range(1, 2 * OS);
            send(rd, rstop, s);
            if (rgap > 0) line(1'b1, rgap);
            if (rstop) last_good = rd;
            expect_event($sformatf("rnd%0d", i), ~rstop, last_good, s + PULSE_OFS);
        end
        line(1'b1, 2 * OS);
        check("no_stray_events", evq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
